// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter slice.
package i2c_pkg;

  localparam int unsigned I2C_BIT_W = 3;
  localparam logic [I2C_BIT_W-1:0] I2C_LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    XFER     = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester and I2C byte-FSM signals seen by the arbiter; master = arbiter side.
interface i2c_master_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import i2c_pkg::*;

  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     req_rw;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     done;
  logic                 err;
  logic                 busy;
  logic                 fsm_ena;
  logic                 fsm_rw;
  logic                 fsm_ack;
  logic [I2C_BIT_W-1:0] fsm_bit_cnt;

  modport master (
    input  req, req_rw, fsm_ack, fsm_bit_cnt,
    output gnt, done, err, busy, fsm_ena, fsm_rw
  );

  modport slave (
    output req, req_rw, fsm_ack, fsm_bit_cnt,
    input  gnt, done, err, busy, fsm_ena, fsm_rw
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, with wrap.
module i2c_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C byte FSM among N_REQ requesters.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_master_arbiter_if.master  bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ena_q, ena_d;
  logic             rw_q, rw_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;

  i2c_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Binary index of the one-hot winner, kept for the pointer update.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rw_d    = rw_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    timer_d = timer_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = WAIT_ACK;
          gnt_d   = pick_win;
          win_d   = pick_idx;
          rw_d    = |(bus.req_rw & pick_win);
          timer_d = '0;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TW'(1);
        // Ack has priority over an expiring timer in the same cycle.
        if (bus.fsm_ack) begin
          state_d = XFER;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = RELEASE;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end
      end
      XFER: begin
        if (bus.fsm_bit_cnt == I2C_LAST_BIT) begin
          state_d = RELEASE;
          done_d  = gnt_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        rw_d    = 1'b0;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
      end
    endcase

    ena_d  = (state_d == WAIT_ACK) || (state_d == XFER);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ena_q   <= 1'b0;
      rw_q    <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ena_q   <= ena_d;
      rw_q    <= rw_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      timer_q <= timer_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.fsm_ena = ena_q;
  assign bus.fsm_rw  = rw_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: driver pushes expected grants/dones, monitor checks.
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct {
    int idx;
    int rw;
    int err;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_ptr = 0;
  int   cur_rw = 0;
  exp_t exp_gnt[$];
  exp_t exp_done[$];
  exp_t e;
  logic [N-1:0] prev_gnt = '0;

  i2c_master_arbiter_if #(.N_REQ(N)) bus ();

  i2c_master_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (bit_of(v, i)) begin
        idx = i;
        cnt++;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  // Reference: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (bit_of(r, (model_ptr + i) % N)) return (model_ptr + i) % N;
    end
    return -1;
  endfunction

  // One transaction starting in an IDLE cycle; t<0 means the FSM never acks.
  task automatic run_txn(input logic [N-1:0] rv, input logic [N-1:0] rwv,
                         input int t, input int k);
    int   c0;
    int   w;
    int   done_c;
    exp_t x;
    c0 = cyc;
    w  = model_pick(rv);
    x.idx = w; x.rw = int'(bit_of(rwv, w)); x.err = 0; x.cyc = c0 + 1;
    exp_gnt.push_back(x);
    done_c = (t < 0) ? c0 + 1 + TO : c0 + 3 + t + k;
    x.err = (t < 0) ? 1 : 0; x.cyc = done_c;
    exp_done.push_back(x);
    model_ptr = (w + 1) % N;
    bus.req = rv;
    bus.req_rw = rwv;
    bus.fsm_ack = 1'b0;
    bus.fsm_bit_cnt = 3'($urandom_range(0, 6));
    while (cyc < done_c) begin
      @(negedge clk);
      bus.req = N'($urandom);
      bus.req_rw = N'($urandom);
      if (t >= 0 && cyc == c0 + 1 + t) bus.fsm_ack = 1'b1;
      else if (t >= 0 && cyc > c0 + 1 + t) bus.fsm_ack = 1'($urandom_range(0, 1));
      else bus.fsm_ack = 1'b0;
      if (t >= 0 && cyc == c0 + 2 + t + k) bus.fsm_bit_cnt = 3'd7;
      else bus.fsm_bit_cnt = 3'($urandom_range(0, 6));
    end
  endtask

  task automatic post_txn(input int gap);
    @(negedge clk);
    check("busy_after_release", int'(bus.busy), 0);
    check("ena_after_release", int'(bus.fsm_ena), 0);
    bus.req = '0;
    bus.fsm_ack = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: invariants every cycle, plus scoreboard pops on grant and done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      check("busy_vs_gnt", int'(bus.busy), int'(bus.gnt != '0));
      check("ena_window", int'(bus.fsm_ena), int'(bus.gnt != '0 && bus.done == '0));
      if (bus.done == '0) check("err_without_done", int'(bus.err), 0);
      if (bus.gnt != '0 && prev_gnt == '0) begin
        check("gnt_expected", int'(exp_gnt.size() > 0), 1);
        if (exp_gnt.size() > 0) begin
          e = exp_gnt.pop_front();
          check("gnt_idx", oh_idx(bus.gnt), e.idx);
          check("gnt_cycle", cyc, e.cyc);
          cur_rw = e.rw;
        end
      end
      if (bus.gnt != '0) begin
        check("rw_held", int'(bus.fsm_rw), cur_rw);
        if (prev_gnt != '0) check("gnt_stable", int'(bus.gnt), int'(prev_gnt));
      end
      if (bus.done != '0) begin
        check("done_expected", int'(exp_done.size() > 0), 1);
        check("done_matches_gnt", int'(bus.done), int'(bus.gnt));
        if (exp_done.size() > 0) begin
          e = exp_done.pop_front();
          check("done_idx", oh_idx(bus.done), e.idx);
          check("done_err", int'(bus.err), e.err);
          check("done_cycle", cyc, e.cyc);
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    int   c0;
    exp_t x;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_rw = '0;
    bus.fsm_ack = 1'b0;
    bus.fsm_bit_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ena", int'(bus.fsm_ena), 0);
    check("rst_rw", int'(bus.fsm_rw), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Contention: all request, each drops after service; then a fresh round.
    run_txn(4'b1111, 4'b1010, 4, 6); post_txn(0);
    run_txn(4'b1110, 4'b1010, 4, 6); post_txn(0);
    run_txn(4'b1100, 4'b1010, 4, 6); post_txn(0);
    run_txn(4'b1000, 4'b1010, 4, 6); post_txn(0);
    run_txn(4'b1111, 4'b0000, 4, 6); post_txn(1);

    // Single nominal read transfer.
    run_txn(4'b0001, 4'b0001, 4, 6); post_txn(0);

    // Fairness between two persistent requesters.
    repeat (4) begin
      run_txn(4'b0101, 4'b0100, 2, 3); post_txn(0);
    end

    // Timeout, then ack coinciding with the final timer cycle.
    run_txn(4'b0001, 4'b0000, -1, 0); post_txn(0);
    run_txn(4'b0011, 4'b0011, TO - 1, 3); post_txn(0);

    // Reset in the middle of XFER: no done, state back to reset values.
    c0 = cyc;
    x.idx = model_pick(4'b0001); x.rw = 0; x.err = 0; x.cyc = c0 + 1;
    exp_gnt.push_back(x);
    bus.req = 4'b0001;
    bus.req_rw = 4'b0000;
    while (cyc < c0 + 8) begin
      @(negedge clk);
      bus.req = N'($urandom);
      bus.fsm_ack = (cyc == c0 + 5) ? 1'b1 : 1'b0;
      bus.fsm_bit_cnt = 3'd2;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", int'(bus.gnt), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_err", int'(bus.err), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ena", int'(bus.fsm_ena), 0);
    model_ptr = 0;
    bus.req = '0;
    bus.fsm_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_txn(4'b0100, 4'b0100, 4, 6); post_txn(0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] rv;
      int mode;
      int t;
      rv = N'($urandom_range(1, (1 << N) - 1));
      mode = int'($urandom_range(0, 9));
      if (mode == 0) t = -1;
      else if (mode == 1) t = TO - 1;
      else t = int'($urandom_range(0, TO - 2));
      run_txn(rv, N'($urandom), t, int'($urandom_range(0, 6)));
      post_txn(int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("gnt_queue_drained", exp_gnt.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares the single-master I2C byte FSM among N_REQ requesters.
- Picks one pending requester by round-robin and drives the FSM's ena/rw for that requester.
- Watches the FSM's ack and bit-count outputs to detect transfer completion.
- Signals done or timeout-error back to the granted requester. Sits between client logic and the I2C FSM.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles in WAIT_ACK before abort (must be >= 5)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req  in  N_REQ  per-requester transfer request, level; held until done
req_rw  in  N_REQ  per-requester direction, 1=read 0=write; sampled with req
gnt  out  N_REQ  one-hot grant, registered
done  out  N_REQ  one-cycle completion pulse to granted requester
err  out  1  qualifies done: 1 = aborted by timeout; 0 otherwise
busy  out  1  high whenever state != IDLE
fsm_ena  out  1  enable to I2C FSM
fsm_rw  out  1  direction to I2C FSM
fsm_ack  in  1  registered ack from FSM, high the cycle after FSM ACK state
fsm_bit_cnt  in  3  FSM bit counter

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state=IDLE.
  - gnt, done, err, busy, fsm_ena, fsm_rw = 0.
  - Priority pointer set so index 0 is highest priority.
  - Timer = 0.
- Reset mid-transfer returns to these values immediately. No done is issued for the aborted transfer.
- States: IDLE, WAIT_ACK, XFER, RELEASE.
- fsm_ena is a decode of the registered state: 1 in WAIT_ACK and XFER, else 0.
- fsm_rw is the latched direction, held from grant through RELEASE.
- IDLE:
  - If any req bit is set, choose the first set bit searching upward (with wrap) from the pointer.
  - Next cycle: gnt=onehot(winner), rw latched from req_rw[winner], timer=0, state WAIT_ACK.
  - If no req is set, remain in IDLE.
- WAIT_ACK:
  - Timer increments each cycle.
  - fsm_ack=1 -> XFER.
  - Else if timer == TIMEOUT-1 -> RELEASE with err flag set.
  - fsm_ack and timeout in the same cycle: ack wins.
- XFER:
  - fsm_bit_cnt == 3'd7 -> RELEASE, err flag clear.
  - No timeout applies in XFER.
- RELEASE, exactly one cycle:
  - done[winner]=1 and err=flag.
  - gnt cleared at the end of this cycle.
  - Pointer = winner+1 mod N_REQ.
  - Next state IDLE.
  - Because fsm_ena=0 here, the FSM's STOP state returns to READY.
- req/req_rw are sampled only in IDLE. Changes or drops after grant are ignored, and the transfer completes.
- Simultaneous requests: exactly one grant. Every requester is granted within N_REQ transactions.
- Nominal latency with no stall:
  - req seen in IDLE at cycle 0.
  - gnt/fsm_ena at cycle 1.
  - fsm_ack at cycle 5.
  - XFER from cycle 6.
  - bit_cnt==7 at cycle 12.
  - done at cycle 13.
  - IDLE at cycle 14; next grant earliest at cycle 15.
- err is 0 whenever done is all-zero.

Decomposition:
- Shared package i2c_pkg holds:
  - arb_state_t enum (IDLE, WAIT_ACK, XFER, RELEASE).
  - I2C_LAST_BIT = 3'd7.
- One sub-module, i2c_rr_pick:
  - Parameter N_REQ.
  - Inputs req and ptr; output one-hot win and valid.
  - Purely combinational round-robin search.
- The pointer register lives in i2c_master_arbiter.

Test Plan:
- Single request: req=4'b0001, req_rw=1; FSM model acks at cycle 5 -> gnt=0001 and fsm_ena at cycle 1, fsm_rw=1, done=0001 with err=0 at cycle 13, busy low at 14.
- Contention: req=4'b1111 held, each requester dropping req after its done -> grant order 0,1,2,3. The next round after all re-request starts at 0 again.
- Fairness: req[0] and req[2] held continuously -> grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Timeout: FSM model never acks, TIMEOUT=16 -> done=0001 with err=1 at cycle 17, fsm_ena low from cycle 17, pointer advances to 1.
- Ack/timeout coincidence: fsm_ack asserted in the timer==15 cycle -> XFER entered, err=0 on the later done.
- Reset mid-XFER: drop rst_n at cycle 8 -> gnt, done, err, busy, fsm_ena = 0 immediately, no done pulse. After release, req=4'b0100 -> grant 0100.
